// File: rtl/aes_rx_pkg.sv
// Shared definitions for the AES receive-side block assembler.
//   BYTE_W      : width of one received byte
//   BLOCK_BYTES : bytes per AES block
//   BLOCK_W     : width of one assembled block
//   CNT_W       : width of the in-block byte counter
//   rx_state_e  : assembler states (IDLE, FILL, PEND)
package aes_rx_pkg;

    localparam int BYTE_W      = 8;
    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = BYTE_W * BLOCK_BYTES;
    localparam int CNT_W       = $clog2(BLOCK_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PEND = 2'd2
    } rx_state_e;

endpackage

// File: rtl/rx_timeout_ctr.sv
// Generic idle-timeout counter.
//   clk     : clock
//   reset   : synchronous active-high reset
//   enable  : counter runs only while high; held at zero otherwise
//   kick    : activity this cycle; restarts the count
//   expired : combinational, high on the cycle the count reaches LIMIT-1
//             without a kick (the LIMIT-th consecutive idle cycle)
module rx_timeout_ctr
    import aes_rx_pkg::*;
#(
    parameter int LIMIT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] count_reg;

    assign expired = enable && !kick && (count_reg == W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset || !enable || kick || expired) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + W'(1);
        end
    end

endmodule

// File: rtl/rx_block_assembler.sv
// Collects received bytes MSB-first into one AES block and hands it to the
// block buffer. A block completed while the buffer reports full is held
// (PEND) until space frees; bytes arriving meanwhile are dropped.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset (highest priority)
//   byte_in      : received byte, qualified by byte_valid
//   buf_full     : buffer overflow flag; blocks hand-off while high
//   flush        : discard partial/pending block, clear sticky errors
//   block_out    : last completed block, stable between shift_done pulses
//   shift_done   : one-cycle pulse when block_out has just been loaded
//   busy         : high in FILL or PEND
//   byte_count   : bytes collected in the current block
//   drop_err     : sticky, byte discarded while a block was pending
//   timeout_err  : sticky, partial block discarded by idle timeout
//
// Build option: define RX_TIMEOUT_EN to discard a partial block after
// TIMEOUT_CYCLES idle cycles in FILL; otherwise timeout_err is tied 0.
module rx_block_assembler
    import aes_rx_pkg::*;
#(
    parameter int BLOCK_BYTES    = aes_rx_pkg::BLOCK_BYTES,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    input  logic                          buf_full,
    input  logic                          flush,
    output logic [8*BLOCK_BYTES-1:0]      block_out,
    output logic                          shift_done,
    output logic                          busy,
    output logic [$clog2(BLOCK_BYTES)-1:0] byte_count,
    output logic                          drop_err,
    output logic                          timeout_err
);

    localparam int BW = 8 * BLOCK_BYTES;
    localparam int CW = $clog2(BLOCK_BYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_BYTES - 1);

    rx_state_e       state_reg, state_next;
    logic [BW-1:0]   sr_reg;
    logic [BW-1:0]   sr_shifted;
    logic [CW-1:0]   byte_count_reg;
    logic [BW-1:0]   block_out_reg;
    logic            shift_done_reg;
    logic            drop_err_reg;
    logic            timeout_hit;

    // FSM outputs
    logic            take_byte;
    logic            complete;

    assign sr_shifted = {sr_reg[BW-9:0], byte_in};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: if (byte_valid) state_next = FILL;
                FILL: begin
                    if (complete) begin
                        state_next = buf_full ? PEND : IDLE;
                    end else if (timeout_hit) begin
                        state_next = IDLE;
                    end
                end
                PEND: if (!buf_full) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy      = 1'b0;
        take_byte = 1'b0;
        complete  = 1'b0;
        unique case (state_reg)
            IDLE: take_byte = byte_valid;
            FILL: begin
                busy      = 1'b1;
                take_byte = byte_valid;
                complete  = byte_valid && (byte_count_reg == LAST_IDX);
            end
            PEND: busy = 1'b1;
            default: ;
        endcase
    end

    // Datapath: shift register, counter, output register, sticky drop flag
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_reg         <= '0;
            byte_count_reg <= '0;
            block_out_reg  <= '0;
            shift_done_reg <= 1'b0;
            drop_err_reg   <= 1'b0;
        end else begin
            shift_done_reg <= 1'b0;
            if (flush) begin
                // block_out deliberately untouched: the buffer may still sample it
                sr_reg         <= '0;
                byte_count_reg <= '0;
                drop_err_reg   <= 1'b0;
            end else begin
                if (take_byte) begin
                    sr_reg <= sr_shifted;
                end
                unique case (state_reg)
                    IDLE: if (take_byte) byte_count_reg <= CW'(1);
                    FILL: begin
                        if (complete) begin
                            byte_count_reg <= '0;
                            if (!buf_full) begin
                                block_out_reg  <= sr_shifted;
                                shift_done_reg <= 1'b1;
                            end
                        end else if (take_byte) begin
                            byte_count_reg <= byte_count_reg + CW'(1);
                        end else if (timeout_hit) begin
                            sr_reg         <= '0;
                            byte_count_reg <= '0;
                        end
                    end
                    PEND: begin
                        // sr holds the finished block; a byte here is lost
                        // even on the release cycle
                        if (byte_valid) drop_err_reg <= 1'b1;
                        if (!buf_full) begin
                            block_out_reg  <= sr_reg;
                            shift_done_reg <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef RX_TIMEOUT_EN
    logic timeout_err_reg;

    rx_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (state_reg == FILL),
        .kick    (byte_valid),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            timeout_err_reg <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err_reg <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign block_out  = block_out_reg;
    assign shift_done = shift_done_reg;
    assign byte_count = byte_count_reg;
    assign drop_err   = drop_err_reg;

endmodule

// File: tb/tb_rx_block_assembler.sv
// Scoreboard bench for rx_block_assembler. A queue-based reference model
// (list of collected bytes + pending block) predicts every cycle; completed
// blocks are pushed to a queue and popped by the monitor on shift_done.
module tb_rx_block_assembler;

    localparam int TMO = 50;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   byte_in = '0;
    logic         byte_valid = 1'b0;
    logic         buf_full = 1'b0;
    logic         flush = 1'b0;
    logic [127:0] block_out;
    logic         shift_done;
    logic         busy;
    logic [3:0]   byte_count;
    logic         drop_err;
    logic         timeout_err;

    rx_block_assembler #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .buf_full    (buf_full),
        .flush       (flush),
        .block_out   (block_out),
        .shift_done  (shift_done),
        .busy        (busy),
        .byte_count  (byte_count),
        .drop_err    (drop_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // reference model state
    logic [7:0]   coll[$];
    logic [127:0] exp_q[$];
    bit           m_pending = 1'b0;
    logic [127:0] m_pend_blk = '0;
    logic [127:0] m_out = '0;
    bit           m_sd = 1'b0;
    bit           m_drop = 1'b0;
    bit           m_tmo = 1'b0;
    int           m_idle = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_block();
        logic [127:0] b = '0;
        for (int i = 0; i < 16; i++) b = {b[119:0], coll[i]};
        return b;
    endfunction

    // Apply the rules to the inputs presented for the coming clock edge.
    task automatic model_step();
        m_sd = 1'b0;
        if (reset) begin
            coll.delete();
            exp_q.delete();
            m_pending = 1'b0;
            m_out = '0;
            m_drop = 1'b0;
            m_tmo = 1'b0;
            m_idle = 0;
        end else if (flush) begin
            coll.delete();
            m_pending = 1'b0;
            m_drop = 1'b0;
            m_tmo = 1'b0;
            m_idle = 0;
        end else if (m_pending) begin
            if (byte_valid) m_drop = 1'b1;
            if (!buf_full) begin
                m_out = m_pend_blk;
                m_sd = 1'b1;
                exp_q.push_back(m_pend_blk);
                m_pending = 1'b0;
            end
        end else if (byte_valid) begin
            coll.push_back(byte_in);
            m_idle = 0;
            if (coll.size() == 16) begin
                if (buf_full) begin
                    m_pending = 1'b1;
                    m_pend_blk = pack_block();
                end else begin
                    m_out = pack_block();
                    m_sd = 1'b1;
                    exp_q.push_back(m_out);
                end
                coll.delete();
            end
        end else if (coll.size() > 0) begin
`ifdef RX_TIMEOUT_EN
            m_idle++;
            if (m_idle == TMO) begin
                coll.delete();
                m_tmo = 1'b1;
                m_idle = 0;
            end
`endif
        end
    endtask

    task automatic drive(input bit r, input bit f, input bit bv, input logic [7:0] b, input bit bf);
        @(negedge clk);
        reset = r;
        flush = f;
        byte_valid = bv;
        byte_in = b;
        buf_full = bf;
        model_step();
    endtask

    task automatic idle(input int n, input bit bf);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, bf);
    endtask

    task automatic send_bytes(input logic [7:0] first, input int n, input bit bf_last);
        for (int i = 0; i < n; i++)
            drive(0, 0, 1, first + 8'(i), (i == n - 1) ? bf_last : 1'b0);
    endtask

    // Monitor: compares DUT against the model each cycle, pops on shift_done.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_en) begin
                chk("shift_done", 128'(shift_done), 128'(m_sd));
                chk("block_out", block_out, m_out);
                chk("busy", 128'(busy), 128'(coll.size() > 0 || m_pending));
                chk("byte_count", 128'(byte_count), 128'(coll.size()));
                chk("drop_err", 128'(drop_err), 128'(m_drop));
                chk("timeout_err", 128'(timeout_err), 128'(m_tmo));
                if (shift_done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL pulse_unexpected cycle=%0d actual=pulse required=none block=%h", cyc, block_out);
                    end else begin
                        chk("pulse_block", block_out, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [127:0] ref_blk;
        int           dens;
        bit           r, f, bv, bf;

        drive(1, 0, 0, 8'h00, 0);
        mon_en = 1'b1;
        idle(2, 0);

        // single block 00..0F
        send_bytes(8'h00, 16, 0);
        idle(1, 0);
        ref_blk = 128'h000102030405060708090A0B0C0D0E0F;
        chk("first_block_const", block_out, ref_blk);
        idle(2, 0);

        // back-to-back blocks
        send_bytes(8'h00, 16, 0);
        send_bytes(8'hF0, 16, 0);
        idle(1, 0);
        ref_blk = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
        chk("second_block_const", block_out, ref_blk);

        // completion while buffer full, 2 bytes dropped, release
        send_bytes(8'h10, 16, 1);
        for (int i = 0; i < 20; i++) drive(0, 0, (i == 5 || i == 12), 8'h77, 1);
        idle(1, 0);
        idle(1, 0);
        ref_blk = 128'h101112131415161718191A1B1C1D1E1F;
        chk("pend_block_const", block_out, ref_blk);

        // byte on the release cycle is dropped and flagged
        send_bytes(8'h20, 16, 1);
        idle(3, 1);
        drive(0, 0, 1, 8'h55, 0);
        idle(2, 0);

        // partial block then flush
        send_bytes(8'h30, 7, 0);
        drive(0, 1, 1, 8'h99, 0);
        send_bytes(8'hA0, 16, 0);
        idle(1, 0);
        ref_blk = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
        chk("after_flush_const", block_out, ref_blk);

        // reset mid-block
        send_bytes(8'h40, 9, 0);
        drive(1, 0, 1, 8'h49, 0);
        send_bytes(8'h50, 16, 0);
        idle(2, 0);

`ifdef RX_TIMEOUT_EN
        send_bytes(8'h60, 5, 0);
        idle(TMO + 3, 0);
        drive(0, 1, 0, 8'h00, 0);
        idle(2, 0);
`endif

        // randomized traffic
        for (int seg = 0; seg < 15; seg++) begin
            dens = $urandom_range(1, 9);
            bf = $urandom_range(0, 1);
            for (int i = 0; i < 200; i++) begin
                r  = ($urandom_range(0, 399) == 0);
                f  = ($urandom_range(0, 149) == 0);
                bv = ($urandom_range(0, 9) < dens);
                if ($urandom_range(0, 11) == 0) bf = ~bf;
                drive(r, f, bv, 8'($urandom_range(0, 255)), bf);
            end
        end

        // drain any pending block
        idle(4, 0);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
